// File: rtl/sdram_responder.sv
// Device-side model of a 16-bit single-chip SDRAM: command decode, per-bank row
// tracking, block-RAM backing store, CAS-latency read pipeline and sticky error flag.
module sdram_responder #(
  parameter int MEM_AW     = 16,
  parameter int TRCD       = 2,
  parameter bit INIT_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sdram_cke,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  output logic [12:0] mode_reg,
  output logic [15:0] ref_count,
  output logic        err,
  output logic [3:0]  err_code
);

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_BST, CMD_PRE, CMD_REF, CMD_LMR
  } cmd_e;

  typedef enum logic [1:0] {ST_UNINIT, ST_PRECHARGED, ST_READY} init_e;

  localparam logic [3:0] TRCD_C = 4'(TRCD);

  cmd_e              cmd_s;
  init_e             init_r;
  logic [3:0]        bank_open_r;
  logic [12:0]       bank_row_r [4];
  logic [2:0]        act_cnt_r [4];
  logic [12:0]       mode_reg_r;
  logic [15:0]       ref_count_r;
  logic              err_r;
  logic [3:0]        err_code_r;
  logic [15:0]       dq_o_r;
  logic              dq_oe_r;
  logic              rd1_vld_r;
  logic              rd1_cl3_r;
  logic              rd2_vld_r;
  logic [15:0]       rd2_data_r;
  logic [15:0]       mem_q_r;
  logic [15:0]       mem_r [2**MEM_AW];

  logic              sel_open_s;
  logic [3:0]        sel_elapsed_s;
  logic              is_rw_s;
  logic              do_write_s;
  logic              do_read_s;
  logic              lmr_cl_ok_s;
  logic              lmr_ok_s;
  logic              eff_cl3_s;
  logic [MEM_AW-1:0] word_idx_s;
  logic [3:0]        code_s;

  // Command decode; deselected or clock-disabled cycles count as NOP
  always_comb begin
    cmd_s = CMD_NOP;
    if (sdram_cke && !sdram_ncs) begin
      case ({sdram_nras, sdram_ncas, sdram_nwe})
        3'b011:  cmd_s = CMD_ACTIVE;
        3'b101:  cmd_s = CMD_READ;
        3'b100:  cmd_s = CMD_WRITE;
        3'b110:  cmd_s = CMD_BST;
        3'b010:  cmd_s = CMD_PRE;
        3'b001:  cmd_s = CMD_REF;
        3'b000:  cmd_s = CMD_LMR;
        default: cmd_s = CMD_NOP;
      endcase
    end else begin
      cmd_s = CMD_NOP;
    end
  end

  // Access qualification and lowest-code-wins violation detection
  always_comb begin
    sel_open_s    = bank_open_r[sdram_ba];
    // act_cnt holds edges since ACTIVE minus one, so +1 gives the spacing of this edge
    sel_elapsed_s = {1'b0, act_cnt_r[sdram_ba]} + 4'd1;
    is_rw_s       = (cmd_s == CMD_READ) || (cmd_s == CMD_WRITE);
    word_idx_s    = MEM_AW'({sdram_ba, bank_row_r[sdram_ba], sdram_a[8:0]});
    do_write_s    = (cmd_s == CMD_WRITE) && sel_open_s;
    do_read_s     = (cmd_s == CMD_READ) && sel_open_s;
    lmr_cl_ok_s   = (sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3);
    lmr_ok_s      = lmr_cl_ok_s && (sdram_a[2:0] == 3'b000) && !(|bank_open_r);
    eff_cl3_s     = (mode_reg_r[6:4] != 3'd2);
    code_s        = 4'd0;
    if (INIT_CHECK && (init_r != ST_READY) && (is_rw_s || cmd_s == CMD_ACTIVE)) begin
      code_s = 4'd1;
    end else if ((cmd_s == CMD_ACTIVE) && sel_open_s) begin
      code_s = 4'd2;
    end else if (is_rw_s && !sel_open_s) begin
      code_s = 4'd3;
    end else if (is_rw_s && (sel_elapsed_s < TRCD_C)) begin
      code_s = 4'd4;
    end else if ((cmd_s == CMD_LMR) && !lmr_cl_ok_s) begin
      code_s = 4'd5;
    end else if ((cmd_s == CMD_LMR) && (sdram_a[2:0] != 3'b000)) begin
      code_s = 4'd6;
    end else if ((cmd_s == CMD_LMR) && (|bank_open_r)) begin
      code_s = 4'd7;
    end else if ((cmd_s == CMD_REF) && (|bank_open_r)) begin
      code_s = 4'd8;
    end else if ((cmd_s == CMD_WRITE) && dq_oe_r) begin
      code_s = 4'd9;
    end else begin
      code_s = 4'd0;
    end
  end

  // Backing store with byte-lane writes and a registered read port; never reset
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      if (!sdram_dqml) mem_r[word_idx_s][7:0]  <= dq_i[7:0];
      if (!sdram_dqmh) mem_r[word_idx_s][15:8] <= dq_i[15:8];
    end
    mem_q_r <= mem_r[word_idx_s];
  end

  // Init FSM, bank tracking, mode/refresh registers, read pipeline and error latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_r      <= ST_UNINIT;
      bank_open_r <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        bank_row_r[b] <= 13'd0;
        act_cnt_r[b]  <= 3'd0;
      end
      mode_reg_r  <= 13'd0;
      ref_count_r <= 16'd0;
      err_r       <= 1'b0;
      err_code_r  <= 4'd0;
      dq_o_r      <= 16'd0;
      dq_oe_r     <= 1'b0;
      rd1_vld_r   <= 1'b0;
      rd1_cl3_r   <= 1'b0;
      rd2_vld_r   <= 1'b0;
      rd2_data_r  <= 16'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (act_cnt_r[b] != 3'd7) act_cnt_r[b] <= act_cnt_r[b] + 3'd1;
      end
      case (cmd_s)
        CMD_ACTIVE: begin
          bank_open_r[sdram_ba] <= 1'b1;
          bank_row_r[sdram_ba]  <= sdram_a;
          act_cnt_r[sdram_ba]   <= 3'd0;
        end
        CMD_READ, CMD_WRITE: begin
          if (sel_open_s && sdram_a[10]) bank_open_r[sdram_ba] <= 1'b0;
        end
        CMD_PRE: begin
          if (sdram_a[10]) begin
            bank_open_r <= 4'b0000;
            if (init_r == ST_UNINIT) init_r <= ST_PRECHARGED;
          end else begin
            bank_open_r[sdram_ba] <= 1'b0;
          end
        end
        CMD_REF: ref_count_r <= ref_count_r + 16'd1;
        CMD_LMR: begin
          mode_reg_r <= sdram_a;
          if ((init_r == ST_PRECHARGED) && lmr_ok_s) init_r <= ST_READY;
        end
        default: begin
        end
      endcase

      // Stage 1 is the RAM read; CL=3 reads take one extra hop through stage 2
      rd1_vld_r  <= do_read_s;
      rd1_cl3_r  <= eff_cl3_s;
      rd2_vld_r  <= rd1_vld_r && rd1_cl3_r;
      rd2_data_r <= mem_q_r;
      if (rd2_vld_r) begin
        dq_o_r  <= rd2_data_r;
        dq_oe_r <= 1'b1;
      end else if (rd1_vld_r && !rd1_cl3_r) begin
        dq_o_r  <= mem_q_r;
        dq_oe_r <= 1'b1;
      end else begin
        dq_o_r  <= 16'd0;
        dq_oe_r <= 1'b0;
      end

      if (!err_r && (code_s != 4'd0)) begin
        err_r      <= 1'b1;
        err_code_r <= code_s;
      end
    end
  end

  assign dq_o      = dq_o_r;
  assign dq_oe     = dq_oe_r;
  assign mode_reg  = mode_reg_r;
  assign ref_count = ref_count_r;
  assign err       = err_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_sdram_responder.sv
// Scenario bench for sdram_responder: a model-driven read scoreboard checked at
// each falling edge plus per-scenario register checks.
module tb_sdram_responder;

  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001, C_LMR = 3'b000, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sdram_cke = 1'b1, sdram_ncs = 1'b0;
  logic        sdram_nras = 1'b1, sdram_ncas = 1'b1, sdram_nwe = 1'b1;
  logic [1:0]  sdram_ba = 2'd0;
  logic [12:0] sdram_a = 13'd0;
  logic        sdram_dqml = 1'b0, sdram_dqmh = 1'b0;
  logic [15:0] dq_i = 16'd0;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [12:0] mode_reg;
  logic [15:0] ref_count;
  logic        err;
  logic [3:0]  err_code;

  typedef struct { logic [15:0] data; int due; } exp_t;
  exp_t        sb_q[$];
  exp_t        exp_item;
  logic [15:0] model [int];
  logic [12:0] tb_row [4];
  int          edge_n = 0;
  int          last_edge = 0;
  int          cur_cl = 3;
  int          total = 0;
  int          bad = 0;

  sdram_responder dut (
    .clk(clk), .reset_n(reset_n), .sdram_cke(sdram_cke), .sdram_ncs(sdram_ncs),
    .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
    .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh),
    .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe), .mode_reg(mode_reg), .ref_count(ref_count),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Read scoreboard: every dq_oe cycle must match the oldest expected read, on its due edge
  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: dq_oe=1 dq_o=%h at edge %0d, required dq_oe=0", dq_o, edge_n);
      end else begin
        exp_item = sb_q.pop_front();
        if (dq_o !== exp_item.data || edge_n != exp_item.due) begin
          bad++;
          $display("FAIL rd_data: got %h at edge %0d, required %h at edge %0d",
                   dq_o, edge_n, exp_item.data, exp_item.due);
        end
      end
    end else if (sb_q.size() != 0 && edge_n >= sb_q[0].due) begin
      total++;
      bad++;
      $display("FAIL rd_missing: dq_oe=%b at edge %0d, required data %h", dq_oe, edge_n, sb_q[0].data);
      void'(sb_q.pop_front());
    end
  end

  task automatic issue(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input logic ml, input logic mh);
    {sdram_nras, sdram_ncas, sdram_nwe} = rcw;
    sdram_ba = ba; sdram_a = a; dq_i = d; sdram_dqml = ml; sdram_dqmh = mh;
    @(posedge clk); #1;
    last_edge = edge_n;
    {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
    sdram_a = 13'd0; dq_i = 16'd0; sdram_dqml = 1'b0; sdram_dqmh = 1'b0;
  endtask

  function automatic int widx(input logic [1:0] ba, input logic [8:0] col);
    logic [23:0] full;
    full = {ba, tb_row[ba], col};
    return int'(full[15:0]);
  endfunction

  task automatic do_act(input logic [1:0] ba, input logic [12:0] row);
    issue(C_ACT, ba, row, 16'd0, 1'b0, 1'b0);
    tb_row[ba] = row;
  endtask

  task automatic do_wr(input logic [1:0] ba, input logic [8:0] col, input logic [15:0] d,
                       input logic ml, input logic mh);
    int i;
    logic [15:0] old;
    i = widx(ba, col);
    old = model.exists(i) ? model[i] : 16'd0;
    model[i] = {mh ? old[15:8] : d[15:8], ml ? old[7:0] : d[7:0]};
    issue(C_WR, ba, {4'd0, col}, d, ml, mh);
  endtask

  task automatic do_rd(input logic [1:0] ba, input logic [12:0] a);
    exp_t e;
    e.data = model[widx(ba, a[8:0])];
    issue(C_RD, ba, a, 16'd0, 1'b0, 1'b0);
    e.due = last_edge + cur_cl - 1;
    sb_q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic init_seq(input logic [12:0] mode);
    issue(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
    issue(C_LMR, 2'd0, mode, 16'd0, 1'b0, 1'b0);
    cur_cl = (mode[6:4] == 3'd2) ? 2 : 3;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d reads pending, required 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic chk_err(input string name, input logic e, input logic [3:0] c);
    total++;
    if (err !== e || err_code !== c) begin
      bad++;
      $display("FAIL %s: err=%b code=%0d, required err=%b code=%0d", name, err, err_code, e, c);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (dq_o !== 16'd0)       begin bad++; $display("FAIL rst_dq_o: %h required 0", dq_o); end
    if (dq_oe !== 1'b0)       begin bad++; $display("FAIL rst_dq_oe: %b required 0", dq_oe); end
    if (mode_reg !== 13'd0)   begin bad++; $display("FAIL rst_mode: %h required 0", mode_reg); end
    if (ref_count !== 16'd0)  begin bad++; $display("FAIL rst_ref: %0d required 0", ref_count); end
    if (err !== 1'b0)         begin bad++; $display("FAIL rst_err: %b required 0", err); end
    if (err_code !== 4'd0)    begin bad++; $display("FAIL rst_code: %0d required 0", err_code); end
  endtask

  task automatic test_init();
    init_seq(13'h220);
    total++;
    if (mode_reg !== 13'h220) begin bad++; $display("FAIL init_mode: %h required 220", mode_reg); end
    chk_err("init_err", 1'b0, 4'd0);
  endtask

  task automatic test_write_read();
    do_act(2'd0, 13'h0012);
    nop(1);
    do_wr(2'd0, 9'd5, 16'hA55A, 1'b0, 1'b0);
    do_rd(2'd0, 13'h005);
    wait_drain();
    chk_err("wr_rd_cl2_err", 1'b0, 4'd0);
    issue(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
    issue(C_LMR, 2'd0, 13'h230, 16'd0, 1'b0, 1'b0);
    cur_cl = 3;
    total++;
    if (mode_reg !== 13'h230) begin bad++; $display("FAIL reload_mode: %h required 230", mode_reg); end
    do_act(2'd0, 13'h0012);
    nop(1);
    do_rd(2'd0, 13'h005);
    wait_drain();
    chk_err("wr_rd_cl3_err", 1'b0, 4'd0);
  endtask

  task automatic test_byte_mask();
    do_wr(2'd0, 9'd5, 16'h1234, 1'b0, 1'b1);
    do_rd(2'd0, 13'h005);
    wait_drain();
    do_wr(2'd0, 9'd5, 16'hFFEE, 1'b1, 1'b0);
    do_rd(2'd0, 13'h005);
    wait_drain();
    chk_err("mask_err", 1'b0, 4'd0);
  endtask

  task automatic test_back_to_back();
    do_wr(2'd0, 9'd0, 16'h1111, 1'b0, 1'b0);
    do_wr(2'd0, 9'd1, 16'h2222, 1'b0, 1'b0);
    do_wr(2'd0, 9'd2, 16'h3333, 1'b0, 1'b0);
    do_rd(2'd0, 13'h000);
    do_rd(2'd0, 13'h001);
    do_rd(2'd0, 13'h002);
    wait_drain();
    chk_err("b2b_err", 1'b0, 4'd0);
  endtask

  task automatic test_closed_bank();
    do_reset();
    init_seq(13'h220);
    issue(C_RD, 2'd1, 13'h005, 16'd0, 1'b0, 1'b0);
    chk_err("closed_bank", 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (dq_oe !== 1'b0) begin bad++; $display("FAIL closed_oe: %b required 0", dq_oe); end
    end
  endtask

  task automatic test_trcd();
    do_reset();
    init_seq(13'h220);
    do_act(2'd0, 13'h0012);
    issue(C_WR, 2'd0, 13'h009, 16'h5555, 1'b0, 1'b0);
    chk_err("trcd", 1'b1, 4'd4);
  endtask

  task automatic test_auto_precharge();
    do_reset();
    init_seq(13'h220);
    do_act(2'd0, 13'h0012);
    nop(1);
    do_rd(2'd0, 13'h401);
    issue(C_RD, 2'd0, 13'h001, 16'd0, 1'b0, 1'b0);
    chk_err("auto_pre", 1'b1, 4'd3);
    wait_drain();
  endtask

  task automatic test_refresh();
    do_reset();
    init_seq(13'h220);
    sdram_cke = 1'b0;
    issue(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
    sdram_cke = 1'b1;
    total++;
    if (ref_count !== 16'd0) begin bad++; $display("FAIL ref_cke0: %0d required 0", ref_count); end
    for (int i = 0; i < 3; i++) issue(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
    total++;
    if (ref_count !== 16'd3) begin bad++; $display("FAIL ref_count3: %0d required 3", ref_count); end
    chk_err("ref_clean", 1'b0, 4'd0);
    do_act(2'd2, 13'h0100);
    nop(2);
    issue(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
    chk_err("ref_open", 1'b1, 4'd8);
    total++;
    if (ref_count !== 16'd4) begin bad++; $display("FAIL ref_count4: %0d required 4", ref_count); end
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    do_reset();
    init_seq(13'h230);
    do_act(2'd0, 13'h0012);
    nop(1);
    do_rd(2'd0, 13'h005);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (dq_oe === 1'b1);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrd_wait: dq_oe never 1, required 1 within 5 edges"); end
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    total++;
    if (dq_oe !== 1'b0) begin bad++; $display("FAIL midrd_oe: %b required 0", dq_oe); end
    chk_err("midrd_err", 1'b0, 4'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_uninit();
    do_reset();
    do_act(2'd0, 13'h0001);
    chk_err("uninit", 1'b1, 4'd1);
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_closed_bank();
    test_trcd();
    test_auto_precharge();
    test_refresh();
    test_reset_mid_read();
    test_uninit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
